// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port of dmem_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// the requesters and the memory taken together.
interface dmem_arbiter_if;
  logic        p0_req_valid;
  logic        p0_req_ready;
  logic        p0_req_we;
  logic [31:0] p0_req_addr;
  logic [31:0] p0_req_wdata;
  logic        p0_rsp_valid;
  logic        p0_rsp_err;
  logic [31:0] p0_rsp_rdata;

  logic        p1_req_valid;
  logic        p1_req_ready;
  logic        p1_req_we;
  logic [31:0] p1_req_addr;
  logic [31:0] p1_req_wdata;
  logic        p1_rsp_valid;
  logic        p1_rsp_err;
  logic [31:0] p1_rsp_rdata;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  p0_req_valid, p0_req_we, p0_req_addr, p0_req_wdata,
    output p0_req_ready, p0_rsp_valid, p0_rsp_err, p0_rsp_rdata,
    input  p1_req_valid, p1_req_we, p1_req_addr, p1_req_wdata,
    output p1_req_ready, p1_rsp_valid, p1_rsp_err, p1_rsp_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output p0_req_valid, p0_req_we, p0_req_addr, p0_req_wdata,
    input  p0_req_ready, p0_rsp_valid, p0_rsp_err, p0_rsp_rdata,
    output p1_req_valid, p1_req_we, p1_req_addr, p1_req_wdata,
    input  p1_req_ready, p1_rsp_valid, p1_rsp_err, p1_rsp_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory. Grants one word access
// per cycle (round-robin or fixed priority), rejects misaligned/out-of-range
// requests without strobing memory, and routes the registered read data back
// to the requester one cycle after acceptance.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES  = 256,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

  localparam logic [31:0] ADDR_MAX = 32'(MEM_BYTES - 4);

  port_t       rr_ptr;
  port_t       grant_port;
  logic        grant_any;
  logic        g_we;
  logic [31:0] g_addr;
  logic [31:0] g_wdata;
  logic        g_legal;

  logic        if_valid;
  port_t       if_port;
  logic        if_we;
  logic        if_err;

  logic        rsp_live;
  logic [31:0] rsp_data;

  // Arbitration: pick the granted port and mux its request fields.
  always_comb begin
    grant_any  = 1'b0;
    grant_port = PORT0;
    if (!rst) begin
      if (bus.p0_req_valid && bus.p1_req_valid) begin
        grant_any  = 1'b1;
        grant_port = FIXED_PRIO ? PORT0 : rr_ptr;
      end else if (bus.p0_req_valid) begin
        grant_any  = 1'b1;
        grant_port = PORT0;
      end else if (bus.p1_req_valid) begin
        grant_any  = 1'b1;
        grant_port = PORT1;
      end
    end

    if (grant_port == PORT1) begin
      g_we    = bus.p1_req_we;
      g_addr  = bus.p1_req_addr;
      g_wdata = bus.p1_req_wdata;
    end else begin
      g_we    = bus.p0_req_we;
      g_addr  = bus.p0_req_addr;
      g_wdata = bus.p0_req_wdata;
    end

    g_legal = (g_addr[1:0] == 2'b00) && (g_addr <= ADDR_MAX);

    bus.p0_req_ready = grant_any && (grant_port == PORT0);
    bus.p1_req_ready = grant_any && (grant_port == PORT1);
    bus.mem_read     = grant_any && g_legal && !g_we;
    bus.mem_write    = grant_any && g_legal && g_we;
    bus.mem_addr     = g_addr;
    bus.mem_wdata    = g_wdata;
  end

  // Round-robin pointer and in-flight access register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= PORT0;
      if_valid <= 1'b0;
      if_port  <= PORT0;
      if_we    <= 1'b0;
      if_err   <= 1'b0;
    end else begin
      if_valid <= grant_any;
      if (grant_any) begin
        rr_ptr  <= (grant_port == PORT0) ? PORT1 : PORT0;
        if_port <= grant_port;
        if_we   <= g_we;
        if_err  <= !g_legal;
      end
    end
  end

  // Response routing. Gating with rst drops a response whose request was
  // accepted just before reset, so it never reaches the requester.
  always_comb begin
    rsp_live         = if_valid && !rst;
    rsp_data         = (if_we || if_err) ? '0 : bus.mem_rdata;
    bus.p0_rsp_valid = 1'b0;
    bus.p0_rsp_err   = 1'b0;
    bus.p0_rsp_rdata = '0;
    bus.p1_rsp_valid = 1'b0;
    bus.p1_rsp_err   = 1'b0;
    bus.p1_rsp_rdata = '0;
    if (rsp_live && (if_port == PORT0)) begin
      bus.p0_rsp_valid = 1'b1;
      bus.p0_rsp_err   = if_err;
      bus.p0_rsp_rdata = rsp_data;
    end
    if (rsp_live && (if_port == PORT1)) begin
      bus.p1_rsp_valid = 1'b1;
      bus.p1_rsp_err   = if_err;
      bus.p1_rsp_rdata = rsp_data;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed requests with hand-computed grants and
// responses; expected responses queue up on acceptance and a negedge monitor
// pops and compares them as the DUT presents responses.
module tb_dmem_arbiter;

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();
  dmem_arbiter_if bus_fp ();

  dmem_arbiter #(.MEM_BYTES(256), .FIXED_PRIO(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  dmem_arbiter #(.MEM_BYTES(256), .FIXED_PRIO(1'b1)) dut_fp (
    .clk (clk),
    .rst (rst),
    .bus (bus_fp)
  );

  // The fixed-priority instance sees the same requests; only its grants matter.
  assign bus_fp.p0_req_valid = bus.p0_req_valid;
  assign bus_fp.p0_req_we    = bus.p0_req_we;
  assign bus_fp.p0_req_addr  = bus.p0_req_addr;
  assign bus_fp.p0_req_wdata = bus.p0_req_wdata;
  assign bus_fp.p1_req_valid = bus.p1_req_valid;
  assign bus_fp.p1_req_we    = bus.p1_req_we;
  assign bus_fp.p1_req_addr  = bus.p1_req_addr;
  assign bus_fp.p1_req_wdata = bus.p1_req_wdata;
  assign bus_fp.mem_rdata    = '0;

  int errors = 0;
  int checks = 0;
  exp_t q[$];

  logic fp_chk = 1'b0;
  logic fp_r0  = 1'b0;
  logic fp_r1  = 1'b0;

  // Byte-addressed memory model, little-endian, registered read.
  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (bus.mem_write) begin
      mem[bus.mem_addr[7:0]]         <= bus.mem_wdata[7:0];
      mem[bus.mem_addr[7:0] + 8'd1]  <= bus.mem_wdata[15:8];
      mem[bus.mem_addr[7:0] + 8'd2]  <= bus.mem_wdata[23:16];
      mem[bus.mem_addr[7:0] + 8'd3]  <= bus.mem_wdata[31:24];
    end
    if (bus.mem_read)
      bus.mem_rdata <= {mem[bus.mem_addr[7:0] + 8'd3], mem[bus.mem_addr[7:0] + 8'd2],
                        mem[bus.mem_addr[7:0] + 8'd1], mem[bus.mem_addr[7:0]]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic put_word(input int unsigned a, input logic [31:0] w);
    mem[a]   = w[7:0];
    mem[a+1] = w[15:8];
    mem[a+2] = w[23:16];
    mem[a+3] = w[31:24];
  endtask

  task automatic req(input logic v0, input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                     input logic v1, input logic we1, input logic [31:0] a1, input logic [31:0] d1);
    bus.p0_req_valid = v0;
    bus.p0_req_we    = we0;
    bus.p0_req_addr  = a0;
    bus.p0_req_wdata = d0;
    bus.p1_req_valid = v1;
    bus.p1_req_we    = we1;
    bus.p1_req_addr  = a1;
    bus.p1_req_wdata = d1;
  endtask

  // One cycle: check grants/strobes mid-cycle, then queue the expected
  // response at the accepting edge when a grant is expected and push is set.
  task automatic step(input logic r0, input logic r1, input logic mr, input logic mw,
                      input logic push, input logic err, input logic [31:0] rdata);
    exp_t e;
    @(negedge clk);
    chk("p0_ready", 32'(bus.p0_req_ready), 32'(r0));
    chk("p1_ready", 32'(bus.p1_req_ready), 32'(r1));
    chk("mem_read", 32'(bus.mem_read), 32'(mr));
    chk("mem_write", 32'(bus.mem_write), 32'(mw));
    if (fp_chk) begin
      chk("fp_p0_ready", 32'(bus_fp.p0_req_ready), 32'(fp_r0));
      chk("fp_p1_ready", 32'(bus_fp.p1_req_ready), 32'(fp_r1));
    end
    @(posedge clk);
    if (push && (r0 || r1)) begin
      e.port  = r1;
      e.err   = err;
      e.rdata = rdata;
      q.push_back(e);
    end
    #1;
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.p0_rsp_valid && bus.p1_rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL rsp_both: got both rsp_valid high, expected at most one at %0t", $time);
    end else if (bus.p0_rsp_valid || bus.p1_rsp_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got rsp on p%0d, expected none at %0t",
                 bus.p1_rsp_valid, $time);
      end else begin
        e = q.pop_front();
        chk("rsp_port", 32'(bus.p1_rsp_valid), 32'(e.port));
        if (bus.p1_rsp_valid) begin
          chk("p1_rsp_err", 32'(bus.p1_rsp_err), 32'(e.err));
          chk("p1_rsp_rdata", bus.p1_rsp_rdata, e.rdata);
          chk("p0_idle", {bus.p0_rsp_rdata[30:0], bus.p0_rsp_err}, 32'h0);
        end else begin
          chk("p0_rsp_err", 32'(bus.p0_rsp_err), 32'(e.err));
          chk("p0_rsp_rdata", bus.p0_rsp_rdata, e.rdata);
          chk("p1_idle", {bus.p1_rsp_rdata[30:0], bus.p1_rsp_err}, 32'h0);
        end
      end
    end
  end

  initial begin
    bus.mem_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    put_word(32'h00, 32'hA0A1A2A3);
    put_word(32'h04, 32'hB0B1B2B3);
    put_word(32'h08, 32'hC0C1C2C3);
    put_word(32'h10, 32'h11223344);
    put_word(32'hFC, 32'hCAFEF00D);

    // Reset with a request pending: no grant, no strobes, no response.
    req(1, 0, 32'h10, 0, 1, 1, 32'h20, 32'h5);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("reset_p0_rsp", {bus.p0_rsp_rdata[30:0], bus.p0_rsp_valid}, 32'h0);
    chk("reset_p1_rsp", {bus.p1_rsp_rdata[30:0], bus.p1_rsp_valid}, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Single read.
    req(1, 0, 32'h10, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1, 0, 32'h11223344);            // rr -> 1
    // Write then read on p1.
    req(0, 0, 0, 0, 1, 1, 32'h20, 32'hDEADBEEF);
    step(0, 1, 0, 1, 1, 0, 32'h0);                   // rr -> 0
    req(0, 0, 0, 0, 1, 0, 32'h20, 0);
    step(0, 1, 1, 0, 1, 0, 32'hDEADBEEF);            // rr -> 0
    // Illegal accesses and the last legal word.
    req(1, 0, 32'h13, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 1, 32'h0);
    req(1, 0, 32'h100, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 1, 32'h0);
    req(1, 0, 32'hFC, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1, 0, 32'hCAFEF00D);            // rr -> 1
    req(0, 0, 0, 0, 1, 1, 32'h21, 32'h12345678);
    step(0, 1, 0, 0, 1, 1, 32'h0);                   // rr -> 0

    // Contention for 4 cycles: round-robin alternates, fixed-priority keeps p0.
    fp_chk = 1'b1;
    fp_r0  = 1'b1;
    fp_r1  = 1'b0;
    req(1, 0, 32'h00, 0, 1, 0, 32'h04, 0);
    step(1, 0, 1, 0, 1, 0, 32'hA0A1A2A3);
    step(0, 1, 1, 0, 1, 0, 32'hB0B1B2B3);
    step(1, 0, 1, 0, 1, 0, 32'hA0A1A2A3);
    step(0, 1, 1, 0, 1, 0, 32'hB0B1B2B3);            // rr -> 0
    fp_chk = 1'b0;

    // Alternating back-to-back stream.
    req(1, 0, 32'h00, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1, 0, 32'hA0A1A2A3);
    req(0, 0, 0, 0, 1, 0, 32'h04, 0);
    step(0, 1, 1, 0, 1, 0, 32'hB0B1B2B3);
    req(1, 0, 32'h08, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1, 0, 32'hC0C1C2C3);
    req(0, 0, 0, 0, 1, 0, 32'h00, 0);
    step(0, 1, 1, 0, 1, 0, 32'hA0A1A2A3);            // rr -> 0

    // Reset mid-operation: this read's response must never appear.
    req(1, 0, 32'h10, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);                       // rr -> 1
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    // rr_ptr back at 0: p0 wins the first contended cycle.
    req(1, 0, 32'h08, 0, 1, 0, 32'h04, 0);
    step(1, 0, 1, 0, 1, 0, 32'hC0C1C2C3);
    step(0, 1, 1, 0, 1, 0, 32'hB0B1B2B3);
    req(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    chk("scoreboard_empty", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
